// File: rtl/irq_scheduler_if.sv
// Register-bus and CPU-side interrupt signals of irq_scheduler.
interface irq_scheduler_if;
  logic [7:0]  din;
  logic [7:0]  address;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;
  logic        interrupt;
  logic [15:0] intVect;
  logic        intAck;

  modport master (
    output din, address, w_en, r_en, intAck,
    input  dout, interrupt, intVect
  );

  modport slave (
    input  din, address, w_en, r_en, intAck,
    output dout, interrupt, intVect
  );
endinterface

// File: rtl/irq_scheduler.sv
// Prioritising 4-source interrupt scheduler with edge latching, in-service tracking and a bus.
// Define IRQ_SCHED_STATS_EN to add per-source saturating ack counters at offsets +8..+11.
module irq_scheduler #(
  parameter logic [7:0]  IRQ_SCHED_ADDRESS = 8'h00,
  parameter int unsigned VECT_SHIFT        = 3
) (
  input  logic           clk,
  input  logic           reset,
  irq_scheduler_if.slave bus,
  input  logic           irq_0,
  input  logic           irq_1,
  input  logic           irq_2,
  input  logic           irq_3
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  irq, irq_prev_q, irq_rise;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  insrv_q, insrv_d;
  logic [7:0]  vbase_l_q, vbase_l_d;
  logic [7:0]  vbase_h_q, vbase_h_d;
  logic        gie_q, gie_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] vect_q, vect_d;
  logic [7:0]  dout_q, dout_d;

  logic [7:0]  offset;
  logic        wr_mask, wr_pend, wr_eoi, wr_vbl, wr_vbh, wr_ctrl;
  logic        ack;
  logic [3:0]  idx_onehot, eoi_bit, blocked, eligible;
  logic [1:0]  win_idx;
  logic [7:0]  stats_rdata;

  assign irq      = {irq_3, irq_2, irq_1, irq_0};
  assign irq_rise = irq & ~irq_prev_q;

  assign offset  = bus.address - IRQ_SCHED_ADDRESS;
  assign wr_mask = bus.w_en && (offset == 8'd0);
  assign wr_pend = bus.w_en && (offset == 8'd1);
  assign wr_eoi  = bus.w_en && (offset == 8'd3);
  assign wr_vbl  = bus.w_en && (offset == 8'd4);
  assign wr_vbh  = bus.w_en && (offset == 8'd5);
  assign wr_ctrl = bus.w_en && (offset == 8'd6);

  assign ack        = bus.intAck && (state_q == StReq);
  assign idx_onehot = 4'b0001 << idx_q;
  // Isolates the lowest set in-service bit.
  assign eoi_bit    = insrv_q & (~insrv_q + 4'd1);

  // A source is blocked by any in-service bit at its own or a higher-priority index.
  assign blocked  = {|insrv_q[3:0], |insrv_q[2:0], |insrv_q[1:0], insrv_q[0]};
  assign eligible = pend_q & ~mask_q & {4{gie_q}} & ~blocked;

  always_comb begin
    win_idx = 2'd0;
    if (eligible[0])      win_idx = 2'd0;
    else if (eligible[1]) win_idx = 2'd1;
    else if (eligible[2]) win_idx = 2'd2;
    else if (eligible[3]) win_idx = 2'd3;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vect_d  = vect_q;
    case (state_q)
      StIdle: begin
        if (|eligible) begin
          idx_d   = win_idx;
          vect_d  = {vbase_h_q, vbase_l_q} + (16'(win_idx) << VECT_SHIFT);
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack)                        state_d = StAck;
        else if (wr_ctrl && !bus.din[0]) state_d = StIdle;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // New edges win over same-cycle w1c and ack clears.
  always_comb begin
    mask_d    = wr_mask ? bus.din[3:0] : mask_q;
    vbase_l_d = wr_vbl  ? bus.din      : vbase_l_q;
    vbase_h_d = wr_vbh  ? bus.din      : vbase_h_q;
    gie_d     = wr_ctrl ? bus.din[0]   : gie_q;
    pend_d    = (pend_q & ~(wr_pend ? bus.din[3:0] : 4'b0) & ~(ack ? idx_onehot : 4'b0))
              | irq_rise;
    insrv_d   = (insrv_q & ~(wr_eoi ? eoi_bit : 4'b0)) | (ack ? idx_onehot : 4'b0);
  end

`ifdef IRQ_SCHED_STATS_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.w_en && (offset == 8'(8 + i))) begin
        cnt_d[i] = 8'h00;
      end else if (ack && (idx_q == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) cnt_q[i] <= 8'h00;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    stats_rdata = 8'h00;
    case (offset)
      8'd8:    stats_rdata = cnt_q[0];
      8'd9:    stats_rdata = cnt_q[1];
      8'd10:   stats_rdata = cnt_q[2];
      8'd11:   stats_rdata = cnt_q[3];
      default: stats_rdata = 8'h00;
    endcase
  end
`else
  assign stats_rdata = 8'h00;
`endif

  always_comb begin
    dout_d = 8'h00;
    if (bus.r_en) begin
      case (offset)
        8'd0:                    dout_d = {4'b0, mask_q};
        8'd1:                    dout_d = {4'b0, pend_q};
        8'd2:                    dout_d = {4'b0, insrv_q};
        8'd4:                    dout_d = vbase_l_q;
        8'd5:                    dout_d = vbase_h_q;
        8'd6:                    dout_d = {7'b0, gie_q};
        8'd8, 8'd9, 8'd10, 8'd11: dout_d = stats_rdata;
        default:                 dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      irq_prev_q <= 4'b0;
      mask_q     <= 4'b0;
      pend_q     <= 4'b0;
      insrv_q    <= 4'b0;
      vbase_l_q  <= 8'h00;
      vbase_h_q  <= 8'h00;
      gie_q      <= 1'b0;
      idx_q      <= 2'd0;
      vect_q     <= 16'h0000;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      insrv_q    <= insrv_d;
      vbase_l_q  <= vbase_l_d;
      vbase_h_q  <= vbase_h_d;
      gie_q      <= gie_d;
      idx_q      <= idx_d;
      vect_q     <= vect_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.interrupt = (state_q == StReq);
  assign bus.intVect   = vect_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: cycle model of the register/priority rules plus literal checks.
module tb_irq_scheduler;
  localparam logic [7:0] Base = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  irq_scheduler_if bus ();

  irq_scheduler #(.IRQ_SCHED_ADDRESS(Base), .VECT_SHIFT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq_0 (irq[0]),
    .irq_1 (irq[1]),
    .irq_2 (irq[2]),
    .irq_3 (irq[3])
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model state: phase 0 = idle, 1 = requesting, 2 = acknowledged.
  logic [3:0]  m_mask, m_pend, m_insrv, m_prev;
  logic [15:0] m_vbase, m_vect;
  logic        m_gie;
  logic [7:0]  m_dout;
  int          m_phase, m_idx;
  int          m_cnt [4];

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    logic [7:0] off;
    logic [3:0] rise, np, ni;
    bit         ack, done;
    int         win;
    if (reset) begin
      m_mask = 0; m_pend = 0; m_insrv = 0; m_prev = 0; m_vbase = 0; m_vect = 0;
      m_gie = 0; m_dout = 0; m_phase = 0; m_idx = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      return;
    end
    off  = bus.address - Base;
    rise = irq & ~m_prev;
    m_prev = irq;
    m_dout = 8'h00;
    if (bus.r_en) begin
      case (off)
        0: m_dout = {4'b0, m_mask};
        1: m_dout = {4'b0, m_pend};
        2: m_dout = {4'b0, m_insrv};
        4: m_dout = m_vbase[7:0];
        5: m_dout = m_vbase[15:8];
        6: m_dout = {7'b0, m_gie};
`ifdef IRQ_SCHED_STATS_EN
        8, 9, 10, 11: m_dout = 8'(m_cnt[int'(off) - 8]);
`endif
        default: m_dout = 8'h00;
      endcase
    end
    ack = (m_phase == 1) && bus.intAck;
    np = m_pend;
    ni = m_insrv;
    if (bus.w_en && off == 1) np = np & ~bus.din[3:0];
    if (bus.w_en && off == 3) begin
      done = 0;
      for (int i = 0; i < 4; i++) if (!done && m_insrv[i]) begin ni[i] = 0; done = 1; end
    end
    if (ack) begin
      np[m_idx] = 0;
      ni[m_idx] = 1;
      if (m_cnt[m_idx] < 255) m_cnt[m_idx]++;
    end
    np = np | rise;
    case (m_phase)
      0: begin
        win = -1;
        for (int i = 0; i < 4; i++)
          if (win < 0 && m_pend[i] && !m_mask[i] && m_gie && (int'(m_insrv) % (2 << i)) == 0)
            win = i;
        if (win >= 0) begin
          m_idx = win;
          m_vect = 16'(int'(m_vbase) + win * 8);
          m_phase = 1;
        end
      end
      1: begin
        if (ack) m_phase = 2;
        else if (bus.w_en && off == 6 && !bus.din[0]) m_phase = 0;
      end
      default: m_phase = 0;
    endcase
    if (bus.w_en) begin
      case (off)
        0: m_mask = bus.din[3:0];
        4: m_vbase[7:0] = bus.din;
        5: m_vbase[15:8] = bus.din;
        6: m_gie = bus.din[0];
        default: ;
      endcase
`ifdef IRQ_SCHED_STATS_EN
      if (off >= 8 && off <= 11) m_cnt[int'(off) - 8] = 0;
`endif
    end
    m_pend = np;
    m_insrv = ni;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (cmp_en) begin
      check("interrupt", {15'b0, bus.interrupt}, {15'b0, m_phase == 1});
      check("intVect", bus.intVect, m_vect);
      check("dout", {8'b0, bus.dout}, {8'b0, m_dout});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    bus.w_en = 1; bus.address = a; bus.din = d;
    step();
    bus.w_en = 0; bus.address = 0; bus.din = 0;
  endtask

  task automatic rd_check(logic [7:0] a, logic [7:0] exp, string name);
    bus.r_en = 1; bus.address = a;
    step();
    bus.r_en = 0; bus.address = 0;
    check(name, {8'b0, bus.dout}, {8'b0, exp});
  endtask

  task automatic pulse(int i);
    irq[i] = 1'b1;
    step();
    irq[i] = 1'b0;
  endtask

  task automatic do_ack();
    bus.intAck = 1;
    step();
    bus.intAck = 0;
  endtask

  task automatic wait_int(int budget, string name);
    int n = 0;
    while (!bus.interrupt && n < budget) begin step(); n++; end
    check(name, {15'b0, bus.interrupt}, 16'h0001);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; irq = 0;
    bus.din = 0; bus.address = 0; bus.w_en = 0; bus.r_en = 0; bus.intAck = 0;
    step(); step();
    reset = 0;
    cmp_en = 1;
    check("reset_interrupt", {15'b0, bus.interrupt}, 16'h0000);
    check("reset_vect", bus.intVect, 16'h0000);
    do_ack();
    rd_check(8'h02, 8'h00, "ack_idle_ignored");

    // 1: single request, latency and ack
    wr(8'h06, 8'h01); wr(8'h04, 8'h00); wr(8'h05, 8'h01);
    pulse(2);
    check("t1_int_lat0", {15'b0, bus.interrupt}, 16'h0000);
    step();
    check("t1_int", {15'b0, bus.interrupt}, 16'h0001);
    check("t1_vect", bus.intVect, 16'h0110);
    do_ack();
    check("t1_ack_low", {15'b0, bus.interrupt}, 16'h0000);
    rd_check(8'h01, 8'h00, "t1_pend");
    rd_check(8'h02, 8'h04, "t1_insrv");

    // 2: in-service blocking and preemption
    wr(8'h03, 8'h00);
    pulse(1); step(); do_ack();
    pulse(3); step(); step();
    check("t2_blocked", {15'b0, bus.interrupt}, 16'h0000);
    rd_check(8'h01, 8'h08, "t2_pend3");
    pulse(0); step();
    check("t2_preempt", {15'b0, bus.interrupt}, 16'h0001);
    check("t2_vect", bus.intVect, 16'h0100);
    do_ack();
    rd_check(8'h02, 8'h03, "t2_insrv2");
    wr(8'h03, 8'h00);
    rd_check(8'h02, 8'h02, "t2_eoi");
    wr(8'h03, 8'h00);
    wait_int(4, "t2_irq3_wait");
    check("t2_vect3", bus.intVect, 16'h0118);
    do_ack(); wr(8'h03, 8'h00);

    // 3: request frozen against later higher-priority edge
    pulse(2); step();
    check("t3_vect2", bus.intVect, 16'h0110);
    pulse(0); step();
    check("t3_frozen", bus.intVect, 16'h0110);
    do_ack(); step(); step();
    check("t3_next_int", {15'b0, bus.interrupt}, 16'h0001);
    check("t3_next_vect", bus.intVect, 16'h0100);
    do_ack(); wr(8'h03, 8'h00); wr(8'h03, 8'h00);
    rd_check(8'h02, 8'h00, "t3_insrv_clr");

    // 4: mask and GIE drop during request
    wr(8'h00, 8'h01);
    pulse(0); step();
    check("t4_masked", {15'b0, bus.interrupt}, 16'h0000);
    rd_check(8'h01, 8'h01, "t4_pend");
    wr(8'h00, 8'h00);
    check("t4_unmask0", {15'b0, bus.interrupt}, 16'h0000);
    step();
    check("t4_unmask1", {15'b0, bus.interrupt}, 16'h0001);
    wr(8'h06, 8'h00);
    check("t4_gie_drop", {15'b0, bus.interrupt}, 16'h0000);
    rd_check(8'h01, 8'h01, "t4_pend_kept");
    wr(8'h01, 8'h01);
    rd_check(8'h01, 8'h00, "t4_w1c");
    wr(8'h06, 8'h01);

    // 5: vector wrap, reset in request, unmapped reads
    wr(8'h04, 8'hF8); wr(8'h05, 8'hFF);
    pulse(1); step();
    check("t5_int", {15'b0, bus.interrupt}, 16'h0001);
    check("t5_wrap", bus.intVect, 16'h0000);
    wr(8'h04, 8'h10);
    reset = 1; step(); reset = 0;
    check("t5_rst_int", {15'b0, bus.interrupt}, 16'h0000);
    check("t5_rst_vect", bus.intVect, 16'h0000);
    rd_check(8'h04, 8'h00, "t5_vbl");
    rd_check(8'h05, 8'h00, "t5_vbh");
    rd_check(8'h06, 8'h00, "t5_ctrl");
    rd_check(8'h01, 8'h00, "t5_pend");
    rd_check(8'h07, 8'h00, "unmapped_7");
    rd_check(8'h20, 8'h00, "unmapped_20");

    // 6: statistics counters
    wr(8'h06, 8'h01);
`ifdef IRQ_SCHED_STATS_EN
    for (int k = 0; k < 300; k++) begin
      pulse(3); step(); do_ack(); wr(8'h03, 8'h00);
    end
    rd_check(8'h0B, 8'hFF, "t6_sat");
    wr(8'h0B, 8'h00);
    rd_check(8'h0B, 8'h00, "t6_clear");
`else
    pulse(3); step(); do_ack(); wr(8'h03, 8'h00);
    wr(8'h08, 8'h55);
    rd_check(8'h08, 8'h00, "t6_no_cnt8");
    rd_check(8'h0B, 8'h00, "t6_no_cnt11");
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
